// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared light codes, phase enum and timer width
package semaforo_pkg;

    localparam int TW = 8;

    localparam logic [2:0] VERDE_C    = 3'b100;
    localparam logic [2:0] AMARELO_C  = 3'b010;
    localparam logic [2:0] VERMELHO_C = 3'b001;

    typedef enum logic [2:0] {
        A_VERDE,
        A_AMARELO,
        LIMPA_AB,
        B_VERDE,
        B_AMARELO,
        LIMPA_BA
    } fase_t;

    function automatic logic [2:0] cor_a(input fase_t f);
        case (f)
            A_VERDE:   cor_a = VERDE_C;
            A_AMARELO: cor_a = AMARELO_C;
            default:   cor_a = VERMELHO_C;
        endcase
    endfunction

    function automatic logic [2:0] cor_b(input fase_t f);
        case (f)
            B_VERDE:   cor_b = VERDE_C;
            B_AMARELO: cor_b = AMARELO_C;
            default:   cor_b = VERMELHO_C;
        endcase
    endfunction

endpackage

// File: rtl/fase_timer.sv
// rtl/fase_timer.sv - per-phase cycle counter with duration latched at phase entry
module fase_timer
    import semaforo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] dur,
    output logic [TW-1:0] cnt,
    output logic          fim
);

    logic [TW-1:0] dur_q;
    logic [TW-1:0] ultimo;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt   <= '0;
            dur_q <= dur;
        end else if (!fim) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A zero duration behaves as one cycle, so the last count is 0 in both cases.
    always_comb begin
        ultimo = (dur_q == '0) ? '0 : dur_q - 1'b1;
        fim    = (cnt == ultimo);
    end

endmodule

// File: rtl/escalonador_cruzamento.sv
// rtl/escalonador_cruzamento.sv - two-approach intersection phase scheduler
module escalonador_cruzamento
    import semaforo_pkg::*;
#(
    parameter logic [7:0] MIN_VERDE = 8'd2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bt,
    input  logic [TW-1:0] t_verde_a,
    input  logic [TW-1:0] t_verde_b,
    input  logic [TW-1:0] t_amarelo,
    input  logic [TW-1:0] t_limpeza,
    output logic [2:0]    A,
    output logic [2:0]    B,
    output logic          espera
);

    fase_t         fase;
    fase_t         prox;
    fase_t         carga;
    logic [TW-1:0] cnt;
    logic [TW-1:0] dur_sel;
    logic [TW:0]   min_ef;
    logic          fim;
    logic          cedo;
    logic          avanca;

    fase_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (avanca),
        .dur  (dur_sel),
        .cnt  (cnt),
        .fim  (fim)
    );

    always_comb begin
        min_ef = (MIN_VERDE == 8'd0) ? 9'd1 : {1'b0, MIN_VERDE};
        cedo   = (fase == A_VERDE) && espera && (({1'b0, cnt} + 9'd1) >= min_ef);
        avanca = fim || cedo;

        case (fase)
            A_VERDE:   prox = A_AMARELO;
            A_AMARELO: prox = LIMPA_AB;
            LIMPA_AB:  prox = B_VERDE;
            B_VERDE:   prox = B_AMARELO;
            B_AMARELO: prox = LIMPA_BA;
            default:   prox = A_VERDE;
        endcase

        // Duration is taken for the phase being entered; reset always enters A green.
        carga = rst ? A_VERDE : prox;
        case (carga)
            A_VERDE:             dur_sel = t_verde_a;
            B_VERDE:             dur_sel = t_verde_b;
            A_AMARELO, B_AMARELO: dur_sel = t_amarelo;
            default:             dur_sel = t_limpeza;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fase   <= A_VERDE;
            A      <= VERDE_C;
            B      <= VERMELHO_C;
            espera <= 1'b0;
        end else begin
            if (avanca) begin
                fase <= prox;
                A    <= cor_a(prox);
                B    <= cor_b(prox);
            end
            // Leaving A green serves the request, even if the button is still held.
            if (fase == A_VERDE && avanca)
                espera <= 1'b0;
            else if (bt)
                espera <= 1'b1;
        end
    end

endmodule

// File: tb/tb_escalonador_cruzamento.sv
// tb/tb_escalonador_cruzamento.sv - directed vector table plus random safety run
module tb_escalonador_cruzamento;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       bt;
    logic [7:0] t_verde_a, t_verde_b, t_amarelo, t_limpeza;
    logic [2:0] A, B;
    logic       espera;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       rst;
        logic       bt;
        logic [7:0] va, vb, am, lim;
        logic       chk;
        logic [2:0] ea, eb;
        logic       eesp;
    } vet_t;

    vet_t tab[$];

    logic [2:0] base_a [10] = '{G, G, G, Y, R, R, R, R, R, G};
    logic [2:0] base_b [10] = '{R, R, R, R, R, G, G, Y, R, R};

    escalonador_cruzamento #(.MIN_VERDE(8'd2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bt        (bt),
        .t_verde_a (t_verde_a),
        .t_verde_b (t_verde_b),
        .t_amarelo (t_amarelo),
        .t_limpeza (t_limpeza),
        .A         (A),
        .B         (B),
        .espera    (espera)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic b, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] am, input logic [7:0] lim, input logic chk,
                       input logic [2:0] ea, input logic [2:0] eb, input logic eesp);
        vet_t v;
        v.rst = r; v.bt = b; v.va = va; v.vb = vb; v.am = am; v.lim = lim;
        v.chk = chk; v.ea = ea; v.eb = eb; v.eesp = eesp;
        tab.push_back(v);
    endtask

    task automatic cmp(input string nome, input int idx, input logic [2:0] got, input logic [2:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s row %0d: got %b expected %b", nome, idx, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic legal(input logic [2:0] c);
        return (c == G) || (c == Y) || (c == R);
    endfunction

    initial begin
        rst = 1'b1; bt = 1'b0;
        t_verde_a = 8'd3; t_verde_b = 8'd2; t_amarelo = 8'd1; t_limpeza = 8'd1;

        // Basic sequence
        add(1, 0, 3, 2, 1, 1, 0, R, R, 0);
        for (int c = 0; c < 10; c++) add(0, 0, 3, 2, 1, 1, 1, base_a[c], base_b[c], 0);

        // Zero yellow/clearance durations: period of 9
        add(1, 0, 3, 2, 0, 0, 0, R, R, 0);
        for (int c = 0; c < 10; c++) add(0, 0, 3, 2, 0, 0, 1, base_a[c], base_b[c], 0);

        // Early end of a long A green
        add(1, 0, 10, 2, 1, 1, 0, R, R, 0);
        add(0, 1, 10, 2, 1, 1, 1, G, R, 0);
        add(0, 0, 10, 2, 1, 1, 1, G, R, 1);
        add(0, 0, 10, 2, 1, 1, 1, Y, R, 0);
        add(0, 0, 10, 2, 1, 1, 1, R, R, 0);
        add(0, 0, 10, 2, 1, 1, 1, R, G, 0);

        // Request during B green carries into the next A green
        add(1, 0, 3, 2, 1, 1, 0, R, R, 0);
        for (int c = 0; c < 5; c++) add(0, 0, 3, 2, 1, 1, 1, base_a[c], base_b[c], 0);
        add(0, 1, 3, 2, 1, 1, 1, R, G, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, G, 1);
        add(0, 0, 3, 2, 1, 1, 1, R, Y, 1);
        add(0, 0, 3, 2, 1, 1, 1, R, R, 1);
        add(0, 0, 3, 2, 1, 1, 1, G, R, 1);
        add(0, 0, 3, 2, 1, 1, 1, G, R, 1);
        add(0, 0, 3, 2, 1, 1, 1, Y, R, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, R, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, G, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, G, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, Y, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, R, 0);
        for (int c = 0; c < 3; c++) add(0, 0, 3, 2, 1, 1, 1, G, R, 0);
        add(0, 0, 3, 2, 1, 1, 1, Y, R, 0);

        // Reset during B yellow with a pending request
        add(1, 0, 3, 2, 1, 1, 0, R, R, 0);
        for (int c = 0; c < 5; c++) add(0, 0, 3, 2, 1, 1, 1, base_a[c], base_b[c], 0);
        add(0, 1, 3, 2, 1, 1, 1, R, G, 0);
        add(0, 0, 3, 2, 1, 1, 1, R, G, 1);
        add(1, 0, 3, 2, 1, 1, 1, R, Y, 1);
        for (int c = 0; c < 3; c++) add(0, 0, 3, 2, 1, 1, 1, G, R, 0);
        add(0, 0, 3, 2, 1, 1, 1, Y, R, 0);

        // A green duration changed mid-phase
        add(1, 0, 3, 2, 1, 1, 0, R, R, 0);
        add(0, 0, 3, 2, 1, 1, 1, G, R, 0);
        for (int c = 1; c < 9; c++) add(0, 0, 6, 2, 1, 1, 1, base_a[c], base_b[c], 0);
        for (int c = 0; c < 6; c++) add(0, 0, 6, 2, 1, 1, 1, G, R, 0);
        add(0, 0, 6, 2, 1, 1, 1, Y, R, 0);

        for (int i = 0; i < tab.size(); i++) begin
            rst = tab[i].rst; bt = tab[i].bt;
            t_verde_a = tab[i].va; t_verde_b = tab[i].vb;
            t_amarelo = tab[i].am; t_limpeza = tab[i].lim;
            if (tab[i].chk) begin
                cmp("A", i, A, tab[i].ea);
                cmp("B", i, B, tab[i].eb);
                cmp("espera", i, {2'b00, espera}, {2'b00, tab[i].eesp});
            end
            @(posedge clk);
            #1;
        end

        // Random durations and button: codes stay legal and never conflict
        rst = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            bt        = ($urandom_range(0, 7) == 0);
            t_verde_a = 8'($urandom_range(0, 5));
            t_verde_b = 8'($urandom_range(0, 5));
            t_amarelo = 8'($urandom_range(0, 3));
            t_limpeza = 8'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            n_total++;
            if (!(legal(A) && legal(B)))
                $display("FAIL legal_code cycle %0d: got A=%b B=%b expected one of 100/010/001", k, A, B);
            else
                n_pass++;
            n_total++;
            if (A != R && B != R)
                $display("FAIL safety cycle %0d: got A=%b B=%b expected at least one 001", k, A, B);
            else
                n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/escalonador_cruzamento.md
# escalonador_cruzamento

Phase scheduler for a two-approach intersection. It shares the crossing between approach A and approach B by sequencing each approach through green, yellow and all-red clearance. Per-phase cycle counts come from configuration inputs, and a latched pedestrian button shortens A's green. It drives the 3-bit light codes consumed by the lamp drivers and sits directly beside the existing `semaforo` light controller.

## Interface
- `MIN_VERDE`, default 8'd2: minimum A-green cycles before a pending pedestrian request may end A's green.
- `clk`  input  1  sole clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `bt`  input  1  pedestrian button. Level-sampled each edge.
- `t_verde_a`  input  8  A green duration, in cycles.
- `t_verde_b`  input  8  B green duration, in cycles.
- `t_amarelo`  input  8  yellow duration, in cycles. Used for both approaches.
- `t_limpeza`  input  8  all-red clearance duration, in cycles.
- `A`  output  3  light code for approach A. Registered.
- `B`  output  3  light code for approach B. Registered.
- `espera`  output  1  pedestrian request pending. Registered.

## Operation
- Light codes: verde=3'b100, amarelo=3'b010, vermelho=3'b001. No other code is ever driven.
- The FSM has six states, visited cyclically:
  - `A_VERDE` (A=verde, B=vermelho)
  - `A_AMARELO` (A=amarelo, B=vermelho)
  - `LIMPA_AB` (both vermelho)
  - `B_VERDE` (A=vermelho, B=verde)
  - `B_AMARELO` (A=vermelho, B=amarelo)
  - `LIMPA_BA` (both vermelho), then back to `A_VERDE`.
- Phase timer: an 8-bit up-counter `cnt` plus an 8-bit latched duration `dur`.
  - On state entry, `cnt` ← 0 and `dur` ← the duration input for the entered state.
  - Effective duration = `dur`, or 1 when `dur`=0. A state lasts exactly its effective duration in cycles.
  - Normal exit occurs when `cnt` == effective−1. `cnt` never wraps.
- Duration inputs are sampled only at state entry. Changing an input mid-phase affects only the next entry into that phase.
- Pedestrian request:
  - `espera` is set on any cycle where `bt`=1.
  - `espera` is cleared on the edge that leaves `A_VERDE`. Clear wins over a simultaneous set.
  - `espera` is not cleared in any other state. A press during the B phases carries into the next `A_VERDE`.
- Early exit: in `A_VERDE`, if `espera`=1 and `cnt`+1 ≥ `MIN_VERDE`, exit at the end of the current cycle.
  - If `MIN_VERDE` ≥ the effective duration, the request does not shorten green.
  - `MIN_VERDE`=0 behaves as 1.
- Safety invariant: A and B are never both non-vermelho.

## Timing
- Reset: any edge with `rst`=1 sets the following, regardless of state:
  - state=`A_VERDE`, `cnt`=0, `dur`=`t_verde_a` (sampled on that edge)
  - A=3'b100, B=3'b001, `espera`=0
- Cycle 0 is the first cycle after the last reset edge. It is cycle 0 of A green.
- Outputs change only on clock edges, in the same edge as the state transition. There is zero extra latency from FSM to the light outputs.
- `bt` high on cycle k makes `espera`=1 from cycle k+1.
  - An early exit can take effect at the earliest at the end of cycle k+1.
- Full period with no requests = sum of effective durations (A green + yellow + clearance + B green + yellow + clearance).
- Reset asserted mid-phase (e.g. during `B_AMARELO`) aborts the phase. The next cycle shows A=verde, B=vermelho.

## Structure
- Package `semaforo_pkg` holds:
  - the color constants `VERDE_C`, `AMARELO_C`, `VERMELHO_C`
  - the state enum `fase_t`
  - width constant `TW`=8
- One sub-module, `fase_timer`: the load/count/done logic. Its inputs are `clk`, `rst`, `load`, `dur`. Its outputs are `cnt` and `fim` (effective-duration reached).
- The early-exit compare and the `espera` latch stay in the top module.

## Test plan
- Basic sequence. Stimulus: `t_verde_a`=3, `t_amarelo`=1, `t_limpeza`=1, `t_verde_b`=2, no `bt`. Required response:
  - A verde in cycles 0–2, A amarelo in cycle 3, both vermelho in cycle 4
  - B verde in cycles 5–6, B amarelo in cycle 7, both vermelho in cycle 8
  - A verde again in cycle 9
- Zero durations. Stimulus: `t_amarelo`=0, `t_limpeza`=0. Required response: each yellow and each clearance lasts exactly 1 cycle. The period with `t_verde_a`=3 and `t_verde_b`=2 is 9.
- Early green end. Stimulus: `t_verde_a`=10, `MIN_VERDE`=2, `bt`=1 in cycle 0 only. Required response:
  - `espera`=1 in cycle 1
  - A amarelo in cycle 2
  - `espera`=0 from cycle 2
- Request during B phase. Stimulus: `bt` pulse while B=verde. Required response:
  - `espera` stays 1 through `LIMPA_BA`
  - the next A green lasts 2 cycles and then `espera` clears
  - the following A green lasts the full `t_verde_a`
- Mid-phase reset and config change. Stimulus:
  - `rst` pulse during `B_AMARELO`: required response is A=3'b100, B=3'b001, `espera`=0 on the next cycle.
  - `t_verde_a` changed 3→6 during A green: required response is that the current green still lasts 3 and the next lasts 6.
- Safety check. Stimulus: random durations and `bt` for 2000 cycles. Required response: the assertion that A and B are never both non-vermelho holds, and codes are always one of the three legal values.
